// File: rtl/tt_temp_sensor_readout.sv
`default_nettype none
// ============================================================================
// Module   : tt_temp_sensor_readout
// Function : Round-robin ring-oscillator frequency readout with per-channel
//            saturating edge counts and hysteretic over-temperature alarms.
// Revision : 1.0 - initial release
// ============================================================================
module tt_temp_sensor_readout #(
   parameter int N_CH      = 4,
   parameter int CNT_W     = 12,
   parameter int GATE_LOG2 = 8,
   parameter int HYST      = 4,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  osc_in,
   input  logic [N_CH-1:0]  ch_mask,
   input  logic             start,
   input  logic             continuous,
   input  logic [CNT_W-1:0] threshold,
   output logic [CNT_W-1:0] result,
   output logic [CH_W-1:0]  result_ch,
   output logic             result_valid,
   output logic             overflow,
   output logic             busy,
   output logic [N_CH-1:0]  alarm
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_COUNT  = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
   localparam logic [GATE_LOG2-1:0] GATE_END = '1;
   localparam logic [CNT_W-1:0]     HYST_C   = CNT_W'(HYST);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [N_CH-1:0]      sync1;
   logic [N_CH-1:0]      sync2;
   logic                 prev;
   logic [CH_W-1:0]      ptr;
   logic [1:0]           settle_cnt;
   logic [GATE_LOG2-1:0] gate_cnt;
   logic [CNT_W-1:0]     cnt;
   logic                 sat;

   logic                 osc_rise;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 sat_nxt;
   logic [CNT_W-1:0]     lo_level;
   logic [CH_W-1:0]      low_idx;
   logic                 low_ok;
   logic [CH_W-1:0]      nxt_idx;
   logic                 nxt_ok;
   logic                 mask_any;

   assign mask_any = |ch_mask;
   assign osc_rise = sync2[ptr] & ~prev;
   assign cnt_nxt  = (osc_rise && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
   assign sat_nxt  = sat | (osc_rise && (cnt == CNT_MAX));
   assign lo_level = (threshold >= HYST_C) ? threshold - HYST_C : '0;

   // Lowest enabled channel and next enabled channel above the pointer.
   always_comb begin
      low_idx = '0;
      low_ok  = 1'b0;
      nxt_idx = '0;
      nxt_ok  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_mask[i] && !low_ok) begin
            low_idx = CH_W'(i);
            low_ok  = 1'b1;
         end
         if (ch_mask[i] && !nxt_ok && (CH_W'(i) > ptr)) begin
            nxt_idx = CH_W'(i);
            nxt_ok  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && mask_any) begin
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_cnt == 2'd2) begin
               state_nxt = S_COUNT;
            end
         end
         S_COUNT: begin
            if (gate_cnt == GATE_END) begin
               state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            if (nxt_ok || (continuous && mask_any)) begin
               state_nxt = S_SETTLE;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
   end

   // Results are captured on the last gate cycle so they are visible
   // together with result_valid throughout the REPORT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1        <= '0;
         sync2        <= '0;
         prev         <= 1'b0;
         ptr          <= '0;
         settle_cnt   <= '0;
         gate_cnt     <= '0;
         cnt          <= '0;
         sat          <= 1'b0;
         result       <= '0;
         result_ch    <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         alarm        <= '0;
      end else begin
         sync1        <= osc_in;
         sync2        <= sync1;
         prev         <= sync2[ptr];
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               settle_cnt <= '0;
               if (start && mask_any) begin
                  ptr <= low_idx;
               end
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               gate_cnt   <= '0;
               cnt        <= '0;
               sat        <= 1'b0;
            end
            S_COUNT: begin
               gate_cnt <= gate_cnt + 1'b1;
               cnt      <= cnt_nxt;
               sat      <= sat_nxt;
               if (gate_cnt == GATE_END) begin
                  result       <= cnt_nxt;
                  result_ch    <= ptr;
                  overflow     <= sat_nxt;
                  result_valid <= 1'b1;
                  if (cnt_nxt >= threshold) begin
                     alarm[ptr] <= 1'b1;
                  end else if (cnt_nxt < lo_level) begin
                     alarm[ptr] <= 1'b0;
                  end
               end
            end
            S_REPORT: begin
               settle_cnt <= '0;
               if (nxt_ok) begin
                  ptr <= nxt_idx;
               end else if (continuous && mask_any) begin
                  ptr <= low_idx;
               end
            end
            default: settle_cnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire
